// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register file's single write port between
// pipeline writeback (priority, zero latency) and a queued multi-cycle unit.
// MC results wait in a DEPTH-entry FIFO. A starvation counter raises stall_o
// so that the queue gets a chance to drain.
// Optional feature: define RFARB_SCOREBOARD_EN to track registers with
// pending MC writes (busy1/busy2). Without it busy1/busy2 are tied low and
// the issue/read inputs are ignored.
module regfile_wr_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_we,
  input  logic [4:0]               wb_wa,
  input  logic [31:0]              wb_wd,
  input  logic                     mc_valid,
  output logic                     mc_ready,
  input  logic [4:0]               mc_wa,
  input  logic [31:0]              mc_wd,
  input  logic                     mc_issue,
  input  logic [4:0]               mc_issue_wa,
  input  logic                     re1,
  input  logic                     re2,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [31:0]              rf_wd,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   q_cnt,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  // FIFO storage and bookkeeping
  logic [4:0]    mem_wa_q [DEPTH];
  logic [31:0]   mem_wd_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, err_q;

  logic          wb_act, empty, full, push, pop, fifo_wr;
  logic [4:0]    head_wa;
  logic [31:0]   head_wd;

  assign wb_act  = wb_we && (wb_wa != 5'd0);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign head_wa = mem_wa_q[rd_ptr_q];
  assign head_wd = mem_wd_q[rd_ptr_q];

  // A full queue refuses new results even when the head leaves this cycle.
  assign mc_ready = !full;
  assign push     = mc_valid && !full;
  // The head leaves whenever WB leaves the port free; an r0 head is discarded.
  assign pop      = !wb_act && !empty;
  assign fifo_wr  = pop && (head_wa != 5'd0);

  // Write-port mux: WB first, then the FIFO head.
  always_comb begin
    rf_we = rst_n && (wb_act || fifo_wr);
    if (wb_act) begin
      rf_wa = wb_wa;
      rf_wd = wb_wd;
    end else begin
      rf_wa = head_wa;
      rf_wd = head_wd;
    end
  end

  // Occupancy and starvation counter next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
    wait_d = wait_q;
    if (pop || empty) begin
      wait_d = '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // FIFO payload storage, written at the tail; no reset needed for data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa_q[wr_ptr_q] <= mc_wa;
      mem_wd_q[wr_ptr_q] <= mc_wd;
    end
  end

  // Pointers, occupancy, starvation stall and sticky contract-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      stall_q <= (wait_d == WW'(MAX_WAIT));
      err_q   <= err_q || (stall_q && wb_act);
    end
  end

  assign q_cnt   = cnt_q;
  assign stall_o = stall_q;
  assign err_o   = err_q;

`ifdef RFARB_SCOREBOARD_EN
  // Pending-write scoreboard; r0 is never busy.
  logic [31:1] busy_q, busy_d;
  logic [31:0] busy_vec;

  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    logic set_b, clr_b;
    assign set_b      = mc_issue && (mc_issue_wa == 5'(gi));
    assign clr_b      = fifo_wr && (head_wa == 5'(gi));
    // Set has priority over a same-cycle clear of the same register.
    assign busy_d[gi] = set_b || (busy_q[gi] && !clr_b);
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = {busy_q, 1'b0};
  assign busy1    = re1 && busy_vec[ra1];
  assign busy2    = re2 && busy_vec[ra2];
`else
  logic unused_sb;
  assign unused_sb = ^{mc_issue, mc_issue_wa, re1, re2, ra1, ra2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule
